// File: rtl/instr_encoder_if.sv
// Instruction-format type and the handshake/field bundle between a tuple source,
// the instruction encoder and the encoded-word sink.
package instr_encoder_pkg;
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3
  } itype_e;
endpackage

interface instr_encoder_if #(
  parameter int ILEN    = 32,
  parameter int REG_LEN = 32,
  parameter int DEPTH   = 4
);
  import instr_encoder_pkg::*;

  localparam int RegBits = $clog2(REG_LEN);
  localparam int CntBits = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  itype_e             in_type;
  logic [6:0]         opcode;
  logic [RegBits-1:0] rs1;
  logic [RegBits-1:0] rs2;
  logic [RegBits-1:0] rd;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [REG_LEN-1:0] imm;
  logic               out_valid;
  logic               out_ready;
  logic [ILEN-1:0]    out_instr;
  logic [REG_LEN-1:0] out_addr;
  logic               flush;
  logic               err;
  logic [7:0]         err_count;
  logic [CntBits-1:0] count;

  // The source/sink side drives the fields, handshakes and flush.
  modport master (
    output in_valid, in_type, opcode, rs1, rs2, rd, funct3, funct7, imm,
           out_ready, flush,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count, count
  );

  modport slave (
    input  in_valid, in_type, opcode, rs1, rs2, rd, funct3, funct7, imm,
           out_ready, flush,
    output in_ready, out_valid, out_instr, out_addr, err, err_count, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/S/B field tuples into instruction words, drops illegal ones with an
// error pulse and count, and queues legal words with their byte addresses.
module instr_encoder #(
  parameter int                 ILEN      = 32,
  parameter int                 REG_LEN   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [REG_LEN-1:0] BASE_ADDR = '0
) (
  input logic           clk,
  input logic           reset,
  instr_encoder_if.slave bus
);
  localparam int PtrBits = $clog2(DEPTH);
  localparam int CntBits = PtrBits + 1;

  localparam logic [2:0] TypeR = 3'd0;
  localparam logic [2:0] TypeI = 3'd1;
  localparam logic [2:0] TypeS = 3'd2;
  localparam logic [2:0] TypeB = 3'd3;

  logic [2:0]         typeBits;
  logic [31:0]        encWord;
  logic               legal;
  logic               immOkIS;
  logic               immOkB;
  logic               full;
  logic               accept;
  logic               push;
  logic               pop;
  logic               drop;

  logic [ILEN-1:0]    mem_q [DEPTH];
  logic [PtrBits-1:0] wrPtr_q, wrPtr_d;
  logic [PtrBits-1:0] rdPtr_q, rdPtr_d;
  logic [CntBits-1:0] count_q, count_d;
  logic [REG_LEN-1:0] addr_q, addr_d;
  logic               err_q, err_d;
  logic [7:0]         errCount_q, errCount_d;

  assign typeBits = bus.in_type;

  // An immediate fits when every bit above the encodable field equals its sign bit.
  assign immOkIS = (&bus.imm[REG_LEN-1:11]) | ~(|bus.imm[REG_LEN-1:11]);
  assign immOkB  = ~bus.imm[0] & ((&bus.imm[REG_LEN-1:12]) | ~(|bus.imm[REG_LEN-1:12]));

  always_comb begin
    encWord = '0;
    legal   = 1'b0;
    case (typeBits)
      TypeR: begin
        encWord = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal   = 1'b1;
      end
      TypeI: begin
        encWord = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        legal   = immOkIS;
      end
      TypeS: begin
        encWord = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        legal   = immOkIS;
      end
      TypeB: begin
        encWord = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   bus.imm[4:1], bus.imm[11], bus.opcode};
        legal   = immOkB;
      end
      default: begin
        encWord = '0;
        legal   = 1'b0;
      end
    endcase
  end

  // No pop credit: a full queue refuses input even while the sink is draining it.
  assign full          = (count_q == CntBits'(DEPTH));
  assign bus.in_ready  = !reset && !full && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal;
  assign drop          = accept && !legal;
  assign bus.out_valid = (count_q != '0);
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  assign bus.out_instr = bus.out_valid ? mem_q[rdPtr_q] : '0;
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_count = errCount_q;
  assign bus.count     = count_q;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    err_d      = drop;
    errCount_d = (drop && errCount_q != 8'hFF) ? errCount_q + 8'd1 : errCount_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
      addr_d  = BASE_ADDR;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PtrBits'(1);
      if (pop) begin
        rdPtr_d = rdPtr_q + PtrBits'(1);
        addr_d  = addr_q + REG_LEN'(4);
      end
      if (push && !pop)      count_d = count_q + CntBits'(1);
      else if (pop && !push) count_d = count_q - CntBits'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
      errCount_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      errCount_q <= errCount_d;
    end
  end

  // Storage needs no reset: the output is masked to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= ILEN'(encWord);
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range-check drops, error saturation,
// full-queue backpressure, ordered drain with addresses, flush and async reset.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  instr_encoder_if #(.ILEN(32), .REG_LEN(32), .DEPTH(4)) bus ();

  instr_encoder #(
    .ILEN(32), .REG_LEN(32), .DEPTH(4), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Presents one tuple for exactly one clock edge.
  task automatic applyStimulus(input itype_e t, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] imm);
    bus.in_type  = t;
    bus.opcode   = op;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    stepClock();
    bus.in_valid = 1'b0;
  endtask

  task automatic pushR(input logic [4:0] rd);
    applyStimulus(R_TYPE, 7'h33, rd, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
  endtask

  task automatic popOne();
    bus.out_ready = 1'b1;
    stepClock();
    bus.out_ready = 1'b0;
  endtask

  task automatic doFlush();
    bus.flush = 1'b1;
    stepClock();
    bus.flush = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_type   = R_TYPE;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.imm       = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) stepClock();

    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("rst_out_instr", bus.out_instr, 32'd0);
    checkOutput("rst_out_addr", bus.out_addr, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(R_TYPE, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checkOutput("r_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("r_instr", bus.out_instr, 32'h002081B3);
    checkOutput("r_addr", bus.out_addr, 32'h0);
    checkOutput("r_count", 32'(bus.count), 32'd1);
    popOne();
    checkOutput("r_pop_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("r_pop_addr", bus.out_addr, 32'h4);
    doFlush();
    checkOutput("flush_addr", bus.out_addr, 32'h0);

    applyStimulus(I_TYPE, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    applyStimulus(S_TYPE, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4);
    checkOutput("is_count", 32'(bus.count), 32'd2);
    checkOutput("i_instr", bus.out_instr, 32'hFFF00293);
    checkOutput("i_addr", bus.out_addr, 32'h0);
    popOne();
    checkOutput("s_instr", bus.out_instr, 32'h0020A223);
    checkOutput("s_addr", bus.out_addr, 32'h4);
    popOne();
    doFlush();

    applyStimulus(B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    checkOutput("b_instr", bus.out_instr, 32'h00208463);
    checkOutput("b_err", 32'(bus.err), 32'd0);
    popOne();
    applyStimulus(B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd9);
    checkOutput("b_odd_err", 32'(bus.err), 32'd1);
    checkOutput("b_odd_err_count", 32'(bus.err_count), 32'd1);
    checkOutput("b_odd_valid", 32'(bus.out_valid), 32'd0);
    stepClock();
    checkOutput("err_pulse_end", 32'(bus.err), 32'd0);

    applyStimulus(I_TYPE, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    checkOutput("i_min_instr", bus.out_instr, 32'h80000293);
    checkOutput("i_min_addr", bus.out_addr, 32'h4);
    popOne();

    pushR(5'd1);
    pushR(5'd2);
    pushR(5'd3);
    checkOutput("pre_rst_count", 32'(bus.count), 32'd3);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(bus.count), 32'd0);
    checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("async_rst_err_count", 32'(bus.err_count), 32'd0);
    checkOutput("async_rst_addr", bus.out_addr, 32'h0);
    stepClock();
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", 32'(bus.in_ready), 32'd1);

    applyStimulus(I_TYPE, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    applyStimulus(itype_e'(3'd5), 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checkOutput("drops_err_count", 32'(bus.err_count), 32'd2);
    checkOutput("drops_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 253; i++)
      applyStimulus(itype_e'(3'd7), 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checkOutput("err_count_255", 32'(bus.err_count), 32'd255);
    applyStimulus(itype_e'(3'd4), 7'h33, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    checkOutput("err_count_sat", 32'(bus.err_count), 32'd255);
    checkOutput("err_at_sat", 32'(bus.err), 32'd1);
    doFlush();
    checkOutput("flush_keeps_err_count", 32'(bus.err_count), 32'd255);

    pushR(5'd1);
    pushR(5'd2);
    pushR(5'd3);
    pushR(5'd4);
    checkOutput("full_count", 32'(bus.count), 32'd4);
    checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_type  = R_TYPE;
    bus.rd       = 5'd5;
    bus.in_valid = 1'b1;
    stepClock();
    checkOutput("held_count", 32'(bus.count), 32'd4);
    checkOutput("held_instr", bus.out_instr, 32'h002080B3);
    checkOutput("held_addr", bus.out_addr, 32'h0);
    bus.out_ready = 1'b1;
    stepClock();
    checkOutput("drain1_instr", bus.out_instr, 32'h00208133);
    checkOutput("drain1_addr", bus.out_addr, 32'h4);
    checkOutput("drain1_count", 32'(bus.count), 32'd3);
    stepClock();
    bus.in_valid = 1'b0;
    checkOutput("drain2_instr", bus.out_instr, 32'h002081B3);
    checkOutput("drain2_addr", bus.out_addr, 32'h8);
    checkOutput("push_pop_count", 32'(bus.count), 32'd3);
    stepClock();
    checkOutput("drain3_instr", bus.out_instr, 32'h00208233);
    checkOutput("drain3_addr", bus.out_addr, 32'hC);
    stepClock();
    checkOutput("drain4_instr", bus.out_instr, 32'h002082B3);
    checkOutput("drain4_addr", bus.out_addr, 32'h10);
    stepClock();
    bus.out_ready = 1'b0;
    checkOutput("drained_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("drained_instr", bus.out_instr, 32'd0);

    pushR(5'd1);
    pushR(5'd2);
    pushR(5'd3);
    checkOutput("pre_flush_count", 32'(bus.count), 32'd3);
    bus.flush    = 1'b1;
    bus.rd       = 5'd4;
    bus.in_valid = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
    stepClock();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("flush_count", 32'(bus.count), 32'd0);
    checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
    pushR(5'd4);
    checkOutput("after_flush_instr", bus.out_instr, 32'h00208233);
    checkOutput("after_flush_addr", bus.out_addr, 32'h0);
    checkOutput("after_flush_count", 32'(bus.count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
